uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among NREQ byte producers. It accepts one byte per grant and drives the transmitter's parallel load port (p_data_tx, data_valid_tx, parity_en, parity_type). It tracks busy_tx so that a new frame launches only after the previous frame has completed. It sits between client logic and the UART TX core, in the clk_tx domain.

## Interface
Parameters:
- DWIDTH, 8, data width per frame (matches UART TX).
- NREQ, 4, number of requesters (2..16).
- BUSY_TMO, 16, cycles allowed for busy_tx to rise after launch (used only with UART_TX_ARB_TMO_EN).

Ports:
- clk_tx  in  1  transmit clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; held high with data stable until gnt seen.
- req_data  in  NREQ*DWIDTH  per-requester byte; slice i = bits [i*DWIDTH +: DWIDTH].
- req_parity_en  in  NREQ  per-requester parity enable.
- req_parity_type  in  NREQ  per-requester parity type (0 even, 1 odd).
- gnt  out  NREQ  one-hot, one-cycle accept pulse.
- owner  out  $clog2(NREQ)  index of the last granted requester.
- p_data_tx  out  DWIDTH  byte to UART TX.
- data_valid_tx  out  1  one-cycle load strobe to UART TX.
- parity_en  out  1  parity enable to UART TX.
- parity_type  out  1  parity type to UART TX.
- busy_tx  in  1  UART TX frame in progress.
- tmo_err  out  1  one-cycle pulse when busy_tx fails to rise (tied 0 without macro).

## Operation
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req is high and busy_tx=0, select the winner by round-robin starting at last+1 (mod NREQ).
  - Register req_data/parity bits of the winner into p_data_tx/parity_en/parity_type.
  - Set owner=winner, pulse gnt[winner], and go to LAUNCH.
  - If busy_tx=1 in IDLE (foreign/leftover frame), no grant is issued.
- LAUNCH: data_valid_tx=1 for exactly this cycle; go to WAIT_BUSY.
- WAIT_BUSY: stay until busy_tx=1, then go to WAIT_DONE.
- WAIT_DONE: stay until busy_tx=0, then go to IDLE.
- Round-robin pointer updates only on grant. A requester that is granted has lowest priority at the next arbitration.
- p_data_tx, parity_en and parity_type hold their values from grant until the next grant. They are never changed mid-frame.
- req is sampled only in IDLE. Requests arriving in other states wait; they are not lost while held high.
- Requester protocol: on the cycle gnt[i]=1 is seen, the requester drops req[i] or presents its next byte. The arbiter ignores req during that cycle (FSM is in LAUNCH).

## Timing
- Reset values:
  - gnt=0, data_valid_tx=0, tmo_err=0.
  - p_data_tx=0, parity_en=0, parity_type=0, owner=0.
  - FSM=IDLE; pointer set so that req[0] has top priority.
- Grant latency: req high in IDLE at edge N gives gnt and data_valid_tx both high in cycle N+1, together with the captured data.
- Frame-to-frame: busy_tx falls at edge M, so IDLE is entered at M+1. The earliest next gnt/data_valid_tx is in cycle M+2.
- busy_tx already high in the LAUNCH cycle is accepted: WAIT_BUSY exits on its first cycle.
- rst asserted in any state returns the FSM to IDLE on the next edge, with all outputs at reset values. A pending gnt/data_valid_tx pulse is cancelled.
- Simultaneous req on all lines: grants follow strict rotation i, i+1, …, one per frame.

## Configuration
- Macro UART_TX_ARB_TMO_EN.
- When defined:
  - A counter runs in WAIT_BUSY.
  - If busy_tx is still 0 after BUSY_TMO cycles in WAIT_BUSY, the FSM returns to IDLE and tmo_err pulses for one cycle.
  - The byte is dropped (not retried) and the pointer keeps its already-updated value.
- When undefined: WAIT_BUSY waits indefinitely, tmo_err is constant 0, and no counter logic is present.

## Test plan
- Single request: req[2]=1, req_data slice 2=0xA5, parity_en=1, parity_type=1 -> next cycle gnt=4'b0100, data_valid_tx=1, p_data_tx=0xA5, parity_en=1, parity_type=1, owner=2.
- Round-robin fairness: req=4'b1111 held, model busy_tx high 10 cycles per frame -> grant order 0,1,2,3,0; exactly one data_valid_tx per busy_tx pulse.
- Back-to-back: after busy_tx falls at edge M with req[1] pending -> gnt[1]/data_valid_tx occur in cycle M+2, not earlier; p_data_tx stable throughout the prior frame.
- Busy at idle: busy_tx=1 externally while req[0]=1 -> no gnt until busy_tx=0, then gnt[0] the following cycle.
- Reset mid-frame: rst=1 during WAIT_DONE -> next cycle all outputs 0 and FSM IDLE; after release with req[3]=1, the grant goes to req[3] (pointer reset).
- With UART_TX_ARB_TMO_EN, BUSY_TMO=16: grant issued and busy_tx held 0 -> tmo_err pulses once, 16 cycles after entering WAIT_BUSY, and the FSM then grants the next pending request.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: bundle between the byte producers, the UART TX core and the
// round-robin arbiter. The slave modport is the arbiter's view; the master
// modport is the surrounding environment (clients plus the UART TX core).
interface uart_tx_arb_if #(
  parameter int DWIDTH = 8,
  parameter int NREQ   = 4
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_parity_en;
  logic [NREQ-1:0]        req_parity_type;
  logic [NREQ-1:0]        gnt;
  logic [OW-1:0]          owner;
  logic [DWIDTH-1:0]      p_data_tx;
  logic                   data_valid_tx;
  logic                   parity_en;
  logic                   parity_type;
  logic                   busy_tx;
  logic                   tmo_err;

  modport master (
    output req, req_data, req_parity_en, req_parity_type, busy_tx,
    input  gnt, owner, p_data_tx, data_valid_tx, parity_en, parity_type, tmo_err
  );

  modport slave (
    input  req, req_data, req_parity_en, req_parity_type, busy_tx,
    output gnt, owner, p_data_tx, data_valid_tx, parity_en, parity_type, tmo_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NREQ byte
// producers. One byte is accepted per grant and held on the parallel load port
// until the next grant; a new frame launches only after busy_tx has completed
// a full high/low cycle for the previous one.
//
// Optional feature: define UART_TX_ARB_TMO_EN to add a busy_tx rise timeout.
// Without it WAIT_BUSY waits forever and tmo_err is tied low.
//
// state     | meaning
// IDLE      | arbitrate pending requests when busy_tx is low
// LAUNCH    | data_valid_tx high for this single cycle
// WAIT_BUSY | waiting for the UART to report the frame started
// WAIT_DONE | waiting for the frame to complete
module uart_tx_arbiter #(
  parameter int DWIDTH   = 8,
  parameter int NREQ     = 4,
  parameter int BUSY_TMO = 16
) (
  input  logic          clk_tx_i,
  input  logic          rst_i,
  uart_tx_arb_if.slave  bus
);
  localparam int OW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 16 || BUSY_TMO < 1) begin : g_bad_param
    $error("uart_tx_arbiter: NREQ must be 2..16 and BUSY_TMO at least 1");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              dv_q, dv_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              pe_q, pe_d;
  logic              pt_q, pt_d;

  logic [DWIDTH-1:0] data_arr [NREQ];
  logic              found;
  logic [OW-1:0]     win;

`ifdef UART_TX_ARB_TMO_EN
  localparam int TW = $clog2(BUSY_TMO + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_q, tmo_d;
`endif

  // Unpack the flat request data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      data_arr[i] = bus.req_data[i*DWIDTH +: DWIDTH];
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[OW'(idx)]) begin
        found = 1'b1;
        win   = OW'(idx);
      end
    end
  end

  // Next-state and output decode; grant captures the winner's byte and parity.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = '0;
    dv_d    = 1'b0;
    data_d  = data_q;
    pe_d    = pe_q;
    pt_d    = pt_q;
`ifdef UART_TX_ARB_TMO_EN
    tmo_cnt_d = tmo_cnt_q;
    tmo_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found && !bus.busy_tx) begin
          state_d = LAUNCH;
          ptr_d   = win;
          owner_d = win;
          gnt_d   = NREQ'(1) << win;
          dv_d    = 1'b1;
          data_d  = data_arr[win];
          pe_d    = bus.req_parity_en[win];
          pt_d    = bus.req_parity_type[win];
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
`ifdef UART_TX_ARB_TMO_EN
        tmo_cnt_d = TW'(BUSY_TMO - 1);
`endif
      end
      WAIT_BUSY: begin
        if (bus.busy_tx) begin
          state_d = WAIT_DONE;
`ifdef UART_TX_ARB_TMO_EN
        end else if (tmo_cnt_q == '0) begin
          // The byte is dropped; the pointer already moved past this owner.
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
`endif
        end
      end
      WAIT_DONE: begin
        if (!bus.busy_tx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset gives requester 0 top priority.
  always_ff @(posedge clk_tx_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= OW'(NREQ - 1);
      owner_q <= '0;
      gnt_q   <= '0;
      dv_q    <= 1'b0;
      data_q  <= '0;
      pe_q    <= 1'b0;
      pt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      dv_q    <= dv_d;
      data_q  <= data_d;
      pe_q    <= pe_d;
      pt_q    <= pt_d;
    end
  end

`ifdef UART_TX_ARB_TMO_EN
  // Busy-rise timeout down-counter and its one-cycle error pulse.
  always_ff @(posedge clk_tx_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end
  assign bus.tmo_err = tmo_q;
`else
  assign bus.tmo_err = 1'b0;
`endif

  assign bus.gnt           = gnt_q;
  assign bus.owner         = owner_q;
  assign bus.p_data_tx     = data_q;
  assign bus.data_valid_tx = dv_q;
  assign bus.parity_en     = pe_q;
  assign bus.parity_type   = pt_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed stimulus with hand-computed expectations for
// the UART TX round-robin arbiter (NREQ=4, DWIDTH=8, BUSY_TMO=16).
module tb_uart_tx_arbiter;
  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  // Free-running transmit clock.
  always #5 clk = ~clk;

  uart_tx_arb_if #(.DWIDTH(DW), .NREQ(NR)) bus();

  uart_tx_arbiter #(.DWIDTH(DW), .NREQ(NR), .BUSY_TMO(TMO)) dut (
    .clk_tx_i (clk),
    .rst_i    (rst),
    .bus      (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the LAUNCH cycle: models a UART frame with busy_tx high for len
  // cycles, checking the load port stays put and no extra strobe appears.
  task automatic run_frame(input int len, input logic [7:0] held);
    step();
    chk("frm_dv_after_launch", 32'(bus.data_valid_tx), 32'd0);
    bus.busy_tx = 1'b1;
    for (int c = 0; c < len; c++) begin
      step();
      chk("frm_dv_in_frame", 32'(bus.data_valid_tx), 32'd0);
      chk("frm_data_stable", 32'(bus.p_data_tx), 32'(held));
    end
    bus.busy_tx = 1'b0;
    step();
    chk("b2b_gnt_not_early", 32'(bus.gnt), 32'd0);
    chk("b2b_dv_not_early", 32'(bus.data_valid_tx), 32'd0);
    chk("frm_data_held", 32'(bus.p_data_tx), 32'(held));
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                 = 1'b1;
    bus.req             = '0;
    bus.req_data        = '0;
    bus.req_parity_en   = '0;
    bus.req_parity_type = '0;
    bus.busy_tx         = 1'b0;
    step();
    step();
    chk("rst_gnt",   32'(bus.gnt), 32'd0);
    chk("rst_dv",    32'(bus.data_valid_tx), 32'd0);
    chk("rst_data",  32'(bus.p_data_tx), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd0);
    chk("rst_pe",    32'(bus.parity_en), 32'd0);
    chk("rst_pt",    32'(bus.parity_type), 32'd0);
    chk("rst_tmo",   32'(bus.tmo_err), 32'd0);
    rst = 1'b0;

    // Single request from requester 2.
    bus.req             = 4'b0100;
    bus.req_data        = 32'h00A5_0000;
    bus.req_parity_en   = 4'b0100;
    bus.req_parity_type = 4'b0100;
    step();
    chk("single_gnt",   32'(bus.gnt), 32'h4);
    chk("single_dv",    32'(bus.data_valid_tx), 32'd1);
    chk("single_data",  32'(bus.p_data_tx), 32'hA5);
    chk("single_pe",    32'(bus.parity_en), 32'd1);
    chk("single_pt",    32'(bus.parity_type), 32'd1);
    chk("single_owner", 32'(bus.owner), 32'd2);
    bus.req = '0;
    run_frame(4, 8'hA5);

    // busy_tx high while idle: no grant until it drops.
    bus.busy_tx         = 1'b1;
    bus.req             = 4'b0001;
    bus.req_data        = 32'h0000_5A3C;
    bus.req_parity_en   = 4'b0010;
    bus.req_parity_type = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("busyidle_no_gnt", 32'(bus.gnt), 32'd0);
    end
    bus.busy_tx = 1'b0;
    step();
    chk("busyidle_gnt",   32'(bus.gnt), 32'h1);
    chk("busyidle_dv",    32'(bus.data_valid_tx), 32'd1);
    chk("busyidle_data",  32'(bus.p_data_tx), 32'h3C);
    chk("busyidle_owner", 32'(bus.owner), 32'd0);

    // Back-to-back: requester 1 raises its request during the frame.
    bus.req = 4'b0010;
    run_frame(5, 8'h3C);
    step();
    chk("b2b_gnt",   32'(bus.gnt), 32'h2);
    chk("b2b_dv",    32'(bus.data_valid_tx), 32'd1);
    chk("b2b_data",  32'(bus.p_data_tx), 32'h5A);
    chk("b2b_pe",    32'(bus.parity_en), 32'd1);
    chk("b2b_pt",    32'(bus.parity_type), 32'd0);
    chk("b2b_owner", 32'(bus.owner), 32'd1);

    // Reset in WAIT_DONE.
    bus.req = '0;
    step();
    bus.busy_tx = 1'b1;
    step();
    step();
    rst                 = 1'b1;
    bus.req             = 4'b1000;
    bus.req_data        = 32'hC300_0000;
    bus.req_parity_en   = 4'b1000;
    bus.req_parity_type = 4'b1000;
    step();
    chk("rstmid_gnt",   32'(bus.gnt), 32'd0);
    chk("rstmid_dv",    32'(bus.data_valid_tx), 32'd0);
    chk("rstmid_data",  32'(bus.p_data_tx), 32'd0);
    chk("rstmid_owner", 32'(bus.owner), 32'd0);
    chk("rstmid_pe",    32'(bus.parity_en), 32'd0);
    chk("rstmid_pt",    32'(bus.parity_type), 32'd0);
    rst         = 1'b0;
    bus.busy_tx = 1'b0;
    step();
    chk("rstmid_gnt3",  32'(bus.gnt), 32'h8);
    chk("rstmid_owner3", 32'(bus.owner), 32'd3);
    chk("rstmid_data3", 32'(bus.p_data_tx), 32'hC3);
    bus.req = '0;
    run_frame(3, 8'hC3);

    // All requesters held: strict rotation 0,1,2,3,0.
    bus.req_data        = 32'h1312_1110;
    bus.req_parity_en   = 4'b1010;
    bus.req_parity_type = 4'b0110;
    bus.req             = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int         idx;
      logic [7:0] bexp;
      logic [3:0] pe_v;
      logic [3:0] pt_v;
      idx  = k % 4;
      bexp = 8'h10 + 8'(idx);
      pe_v = 4'b1010;
      pt_v = 4'b0110;
      step();
      chk("rr_gnt",   32'(bus.gnt), 32'(4'b0001 << idx));
      chk("rr_dv",    32'(bus.data_valid_tx), 32'd1);
      chk("rr_data",  32'(bus.p_data_tx), 32'(bexp));
      chk("rr_pe",    32'(bus.parity_en), 32'(pe_v[idx]));
      chk("rr_pt",    32'(bus.parity_type), 32'(pt_v[idx]));
      chk("rr_owner", 32'(bus.owner), 32'(idx));
      run_frame(10, bexp);
    end

    // Reset on the arbitration edge cancels the pending grant.
    rst = 1'b1;
    step();
    chk("rstcancel_gnt", 32'(bus.gnt), 32'd0);
    chk("rstcancel_dv",  32'(bus.data_valid_tx), 32'd0);
    rst = 1'b0;
    step();
    chk("rstcancel_gnt0", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    run_frame(2, 8'h10);

`ifdef UART_TX_ARB_TMO_EN
    // busy_tx never rises: timeout after 16 WAIT_BUSY cycles, then next grant.
    bus.req = 4'b0100;
    step();
    chk("tmo_gnt2", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0001;
    step();
    for (int c = 0; c < TMO - 1; c++) begin
      step();
      chk("tmo_quiet", 32'(bus.tmo_err), 32'd0);
      chk("tmo_no_gnt", 32'(bus.gnt), 32'd0);
    end
    step();
    chk("tmo_pulse", 32'(bus.tmo_err), 32'd1);
    step();
    chk("tmo_pulse_end", 32'(bus.tmo_err), 32'd0);
    chk("tmo_next_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    run_frame(2, 8'h10);
`else
    chk("tmo_tied_low", 32'(bus.tmo_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
